// File: rtl/fu_writeback_arbiter_pkg.sv
// Shared constants for the FU writeback arbiter: FU indices, sizes and load funct3 encodings.
package fu_writeback_arbiter_pkg;

  localparam int unsigned NumFu  = 5;
  localparam int unsigned Xlen   = 32;
  localparam int unsigned RegW   = 5;
  localparam int unsigned MemIdx = 1;
  localparam int unsigned FuIdxW = 3;

  localparam int unsigned FuAlu  = 0;
  localparam int unsigned FuMem  = 1;
  localparam int unsigned FuMul  = 2;
  localparam int unsigned FuDiv  = 3;
  localparam int unsigned FuJump = 4;

  typedef enum logic [2:0] {
    LdB  = 3'b000,
    LdH  = 3'b001,
    LdW  = 3'b010,
    LdBu = 3'b100,
    LdHu = 3'b101
  } load_op_e;

endpackage

// File: rtl/load_data_ext.sv
// Load alignment and sign/zero extension on the mem FU result path (purely combinational).
module load_data_ext
  import fu_writeback_arbiter_pkg::*;
#(
  parameter int unsigned Width = Xlen
) (
  input  logic [2:0]       bhw_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] byte_sh;
  logic [Width-1:0] half_sh;

  assign byte_sh = din_i >> {addr_lo_i, 3'b000};
  // Halves only look at addr bit 1; misalignment is not trapped here.
  assign half_sh = addr_lo_i[1] ? (din_i >> 16) : din_i;

  always_comb begin
    dout_o = din_i;
    case (load_op_e'(bhw_i))
      LdB:     dout_o = {{(Width - 8){byte_sh[7]}}, byte_sh[7:0]};
      LdH:     dout_o = {{(Width - 16){half_sh[15]}}, half_sh[15:0]};
      LdW:     dout_o = din_i;
      LdBu:    dout_o = {{(Width - 8){1'b0}}, byte_sh[7:0]};
      LdHu:    dout_o = {{(Width - 16){1'b0}}, half_sh[15:0]};
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/fu_writeback_arbiter.sv
// One-entry result buffer per FU, round-robin retirement of one result per cycle onto the
// register-file write port and scoreboard release bus.
module fu_writeback_arbiter
  import fu_writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU   = NumFu,
  parameter int unsigned XLEN     = Xlen,
  parameter int unsigned REG_W    = RegW,
  parameter int unsigned MEM_IDX  = MemIdx,
  parameter int unsigned FU_IDX_W = FuIdxW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*REG_W-1:0]   fu_rd,
  input  logic [NUM_FU*XLEN-1:0]    fu_data,
  input  logic [2:0]                mem_bhw,
  input  logic [1:0]                mem_addr_lo,
  output logic [NUM_FU-1:0]         fu_stall,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [REG_W-1:0]          wb_rd,
  output logic [XLEN-1:0]           wb_data,
  output logic [FU_IDX_W-1:0]       wb_fu
);

  logic [NUM_FU-1:0]   full_q, full_d;
  logic [FU_IDX_W-1:0] rr_q, rr_d;
  logic [REG_W-1:0]    rd_q   [NUM_FU];
  logic [XLEN-1:0]     data_q [NUM_FU];

  logic [NUM_FU-1:0]   grant;
  logic [NUM_FU-1:0]   capture;
  logic                gnt_vld;
  logic [FU_IDX_W-1:0] gnt_idx;
  logic [XLEN-1:0]     mem_ext;
  logic [XLEN-1:0]     cap_data [NUM_FU];

  load_data_ext #(
    .Width (XLEN)
  ) u_load_ext (
    .bhw_i     (mem_bhw),
    .addr_lo_i (mem_addr_lo),
    .din_i     (fu_data[MEM_IDX*XLEN +: XLEN]),
    .dout_o    (mem_ext)
  );

  // Round-robin scan of full buffers starting at rr_q, wrapping modulo NUM_FU.
  always_comb begin
    logic [FU_IDX_W:0] sum;
    sum     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      sum = {1'b0, rr_q} + (FU_IDX_W + 1)'(off);
      if (sum >= (FU_IDX_W + 1)'(NUM_FU)) begin
        sum = sum - (FU_IDX_W + 1)'(NUM_FU);
      end
      if (!gnt_vld && full_q[sum[FU_IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[FU_IDX_W-1:0];
      end
    end
    if (gnt_vld) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + FU_IDX_W'(1);
    end
  end

  // A granted buffer drains this cycle, so it may be refilled at the same edge.
  assign fu_stall = full_q & ~grant;
  assign capture  = fu_valid & ~fu_stall;
  assign full_d   = (full_q & ~grant) | capture;

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      cap_data[i] = (i == MEM_IDX) ? mem_ext : fu_data[i*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      rr_q   <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      rr_q   <= rr_d;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (capture[i]) begin
          rd_q[i]   <= fu_rd[i*REG_W +: REG_W];
          data_q[i] <= cap_data[i];
        end
      end
    end
  end

  assign wb_valid = gnt_vld;
  assign wb_rd    = gnt_vld ? rd_q[gnt_idx] : '0;
  assign wb_data  = gnt_vld ? data_q[gnt_idx] : '0;
  assign wb_fu    = gnt_vld ? gnt_idx : '0;
  assign wb_we    = gnt_vld && (wb_rd != '0);

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_fu_writeback_arbiter;

  localparam int N  = 5;
  localparam int XL = 32;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    fu_valid;
  logic [N*RW-1:0] fu_rd;
  logic [N*XL-1:0] fu_data;
  logic [2:0]      mem_bhw;
  logic [1:0]      mem_addr_lo;
  logic [N-1:0]    fu_stall;
  logic            wb_valid;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XL-1:0]   wb_data;
  logic [2:0]      wb_fu;

  always #5 clk = ~clk;

  fu_writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .fu_valid    (fu_valid),
    .fu_rd       (fu_rd),
    .fu_data     (fu_data),
    .mem_bhw     (mem_bhw),
    .mem_addr_lo (mem_addr_lo),
    .fu_stall    (fu_stall),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_fu       (wb_fu)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: which FUs hold a result, what it is, and where the next scan starts.
  bit            m_full [N];
  logic [RW-1:0] m_rd   [N];
  logic [XL-1:0] m_data [N];
  int            m_rr;
  int            e_g;
  logic [N-1:0]  e_stall;

  function automatic logic [31:0] ref_load(logic [2:0] f, logic [1:0] a, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic eval_model();
    e_g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (e_g < 0 && m_full[idx]) e_g = idx;
    end
    for (int i = 0; i < N; i++) e_stall[i] = m_full[i] && (i != e_g);
  endtask

  task automatic sample();
    logic [31:0] erd, edata, efu;
    @(negedge clk);
    eval_model();
    erd   = (e_g >= 0) ? 32'(m_rd[e_g]) : 32'd0;
    edata = (e_g >= 0) ? m_data[e_g] : 32'd0;
    efu   = (e_g >= 0) ? 32'(e_g) : 32'd0;
    chk("wb_valid", 32'(wb_valid), 32'(e_g >= 0));
    chk("wb_we", 32'(wb_we), 32'((e_g >= 0) && (erd != 0)));
    chk("wb_rd", 32'(wb_rd), erd);
    chk("wb_data", wb_data, edata);
    chk("wb_fu", 32'(wb_fu), efu);
    chk("fu_stall", 32'(fu_stall), 32'(e_stall));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_rr = 0;
    end else begin
      if (e_g >= 0) begin
        m_full[e_g] = 0;
        m_rr = (e_g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && !e_stall[i]) begin
          m_full[i] = 1;
          m_rd[i]   = fu_rd[i*RW +: RW];
          m_data[i] = (i == 1) ? ref_load(mem_bhw, mem_addr_lo, fu_data[i*XL +: XL])
                               : fu_data[i*XL +: XL];
        end
      end
    end
    #1;
  endtask

  task automatic set_fu(input int i, input logic [RW-1:0] rd, input logic [XL-1:0] d);
    fu_valid[i]        = 1'b1;
    fu_rd[i*RW +: RW]  = rd;
    fu_data[i*XL +: XL] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    fu_valid = '0;
    sample();
    advance();
    rst = 1'b0;
  endtask

  logic [2:0]  ld_f [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_a [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_e [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8070, 32'h0000_F0A5,
                            32'h8070_F0A5};

  initial begin
    m_rr = 0;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0;
      m_rd[i]   = '0;
      m_data[i] = '0;
    end
    e_g = -1;
    e_stall = '0;
    rst = 1'b1;
    fu_valid = '1;
    fu_rd = {$urandom, $urandom};
    fu_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mem_bhw = 3'b010;
    mem_addr_lo = 2'd0;

    // Reset held with every FU valid.
    advance();
    sample();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_stall", 32'(fu_stall), 32'd0);
    advance();
    rst = 1'b0;
    fu_valid = '0;
    sample();
    chk("post_rst_empty", 32'(wb_valid), 32'd0);
    advance();

    // Single ALU result, one cycle latency, no bypass.
    set_fu(0, 5'd3, 32'h1234_5678);
    sample();
    chk("alu_no_bypass", 32'(wb_valid), 32'd0);
    advance();
    fu_valid = '0;
    sample();
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_we", 32'(wb_we), 32'd1);
    chk("alu_rd", 32'(wb_rd), 32'd3);
    chk("alu_data", wb_data, 32'h1234_5678);
    chk("alu_fu", 32'(wb_fu), 32'd0);
    advance();

    // Contention: all five at once from rr_ptr 0.
    pulse_reset();
    for (int i = 0; i < N; i++) set_fu(i, 5'(i + 10), 32'(32'hA000_0000 + i));
    mem_bhw = 3'b010;
    sample();
    advance();
    fu_valid = '0;
    for (int c = 0; c < N; c++) begin
      sample();
      chk("burst_fu", 32'(wb_fu), 32'(c));
      chk("burst_valid", 32'(wb_valid), 32'd1);
      if (c < N - 1) chk("burst_stall4", 32'(fu_stall[4]), 32'd1);
      advance();
    end
    for (int i = 0; i < N; i++) set_fu(i, 5'(i + 1), 32'(i));
    sample();
    advance();
    fu_valid = '0;
    sample();
    chk("burst2_first", 32'(wb_fu), 32'd0);
    advance();
    for (int c = 0; c < N; c++) begin
      sample();
      advance();
    end

    // Drain and refill on ALU alone.
    for (int c = 0; c < 4; c++) begin
      fu_valid = '0;
      set_fu(0, 5'(5 + c), 32'(c * 3 + 7));
      sample();
      chk("refill_stall0", 32'(fu_stall[0]), 32'd0);
      if (c > 0) begin
        chk("refill_valid", 32'(wb_valid), 32'd1);
        chk("refill_rd", 32'(wb_rd), 32'(5 + c - 1));
      end
      advance();
    end
    fu_valid = '0;
    sample();
    chk("refill_last", 32'(wb_rd), 32'd8);
    advance();

    // Load extension.
    for (int t = 0; t < 5; t++) begin
      fu_valid = '0;
      set_fu(1, 5'd7, 32'h8070_F0A5);
      mem_bhw = ld_f[t];
      mem_addr_lo = ld_a[t];
      sample();
      advance();
      fu_valid = '0;
      sample();
      chk("load_data", wb_data, ld_e[t]);
      advance();
    end

    // Store with rd=0 still releases the FU.
    set_fu(1, 5'd0, 32'hDEAD_BEEF);
    mem_bhw = 3'b010;
    sample();
    advance();
    fu_valid = '0;
    sample();
    chk("store_valid", 32'(wb_valid), 32'd1);
    chk("store_we", 32'(wb_we), 32'd0);
    chk("store_fu", 32'(wb_fu), 32'd1);
    advance();

    // Reset with three buffers full.
    set_fu(0, 5'd1, 32'h11);
    set_fu(2, 5'd2, 32'h22);
    set_fu(3, 5'd3, 32'h33);
    sample();
    advance();
    fu_valid = '0;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    sample();
    chk("midrst_empty", 32'(wb_valid), 32'd0);
    chk("midrst_stall", 32'(fu_stall), 32'd0);
    advance();

    // Randomized traffic; a stalled FU keeps presenting the same result.
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(fu_valid[i] && e_stall[i])) begin
          fu_valid[i] = ($urandom_range(0, 99) < 45);
          fu_rd[i*RW +: RW] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          fu_data[i*XL +: XL] = $urandom;
          if (i == 1) begin
            mem_bhw = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom);
          end
        end
      end
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
